// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: walks the fixed NS/EW light cycle on
// 1 Hz ticks, shortens green on a latched pedestrian request, and drives
// registered lamp outputs plus the remaining-seconds display.
module traffic_phase_ctrl #(
  parameter int unsigned pGREEN   = 30,
  parameter int unsigned pYELLOW  = 3,
  parameter int unsigned pALL_RED = 2,
  parameter int unsigned pPED_CUT = 5,
  localparam int unsigned pMAX_LEN =
    (pGREEN >= pYELLOW && pGREEN >= pALL_RED) ? pGREEN :
    (pYELLOW >= pALL_RED) ? pYELLOW : pALL_RED,
  localparam int unsigned pCNT_WIDTH = $clog2(pMAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic                  en,
  input  logic                  ped_req,
  output logic                  ped_ack,
  output logic [2:0]            ns_light,
  output logic [2:0]            ew_light,
  output logic [pCNT_WIDTH-1:0] remain,
  output logic                  phase_last,
  output logic                  phase_pre_last,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    StArNs = 3'd0,
    StNsG  = 3'd1,
    StNsY  = 3'd2,
    StArEw = 3'd3,
    StEwG  = 3'd4,
    StEwY  = 3'd5
  } state_e;

  localparam logic [pCNT_WIDTH-1:0] GreenLd  = pCNT_WIDTH'(pGREEN - 1);
  localparam logic [pCNT_WIDTH-1:0] YellowLd = pCNT_WIDTH'(pYELLOW - 1);
  localparam logic [pCNT_WIDTH-1:0] AllRedLd = pCNT_WIDTH'(pALL_RED - 1);
  localparam logic [pCNT_WIDTH-1:0] PedCutLd = pCNT_WIDTH'(pPED_CUT - 1);
  localparam logic [pCNT_WIDTH-1:0] CntOne   = pCNT_WIDTH'(1);

  // State kept as raw bits so the unused encodings 6/7 stay observable and recoverable.
  logic [2:0]            state_q;
  state_e                state_d;
  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ped_pend_q, ped_pend_d;
  logic                  ped_ack_q, ped_ack_d;
  logic [2:0]            ns_q, ns_d;
  logic [2:0]            ew_q, ew_d;

  // Successor decode for the current phase and its reload value.
  state_e                succ;
  logic [pCNT_WIDTH-1:0] succ_ld;
  logic                  legal, in_green, in_yellow;

  always_comb begin
    succ      = StArNs;
    succ_ld   = AllRedLd;
    legal     = 1'b1;
    in_green  = 1'b0;
    in_yellow = 1'b0;
    case (state_q)
      StArNs: begin succ = StNsG;  succ_ld = GreenLd;  end
      StNsG:  begin succ = StNsY;  succ_ld = YellowLd; in_green  = 1'b1; end
      StNsY:  begin succ = StArEw; succ_ld = AllRedLd; in_yellow = 1'b1; end
      StArEw: begin succ = StEwG;  succ_ld = GreenLd;  end
      StEwG:  begin succ = StEwY;  succ_ld = YellowLd; in_green  = 1'b1; end
      StEwY:  begin succ = StArNs; succ_ld = AllRedLd; in_yellow = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Next-state: illegal recovery, then pedestrian clamp, then tick decrement/advance.
  always_comb begin
    state_d    = state_e'(state_q);
    cnt_d      = cnt_q;
    ped_pend_d = ped_pend_q | ped_req;
    ped_ack_d  = 1'b0;
    if (!legal) begin
      state_d = StArNs;
      cnt_d   = AllRedLd;
    end else if (en) begin
      if (in_green && ped_pend_q && (cnt_q > PedCutLd)) begin
        cnt_d = PedCutLd;
      end else if (sec_tick) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d = succ;
          cnt_d   = succ_ld;
          if (in_yellow && ped_pend_q) begin
            ped_ack_d  = 1'b1;
            // A request present on the service cycle is kept for the next green.
            ped_pend_d = ped_req;
          end
        end
      end
    end
  end

  // Lamp decode from the next state so lamps register on the same edge as the state.
  always_comb begin
    ns_d = 3'b100;
    ew_d = 3'b100;
    case (state_d)
      StNsG:   ns_d = 3'b001;
      StNsY:   ns_d = 3'b010;
      StEwG:   ew_d = 3'b001;
      StEwY:   ew_d = 3'b010;
      default: ;
    endcase
  end

  // State, count, pedestrian and lamp registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArNs;
      cnt_q      <= AllRedLd;
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
      ns_q       <= 3'b100;
      ew_q       <= 3'b100;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
    end
  end

  assign ped_ack        = ped_ack_q;
  assign ns_light       = ns_q;
  assign ew_light       = ew_q;
  assign remain         = cnt_q;
  assign phase_last     = (cnt_q == '0);
  assign phase_pre_last = (cnt_q == CntOne);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios followed by
// random stimulus, all compared against a seconds-left reference model.
module tb_traffic_phase_ctrl;

  localparam int unsigned G   = 5;
  localparam int unsigned Y   = 2;
  localparam int unsigned AR  = 1;
  localparam int unsigned CUT = 2;

  logic       clk = 1'b0;
  logic       rst, sec_tick, en, ped_req;
  logic       ped_ack, phase_last, phase_pre_last;
  logic [2:0] ns_light, ew_light, state_dbg;
  logic [2:0] remain;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .pGREEN   (G),
    .pYELLOW  (Y),
    .pALL_RED (AR),
    .pPED_CUT (CUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sec_tick       (sec_tick),
    .en             (en),
    .ped_req        (ped_req),
    .ped_ack        (ped_ack),
    .ns_light       (ns_light),
    .ew_light       (ew_light),
    .remain         (remain),
    .phase_last     (phase_last),
    .phase_pre_last (phase_pre_last),
    .state_dbg      (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase index and whole seconds left in the phase.
  int         m_ph, m_left;
  bit         m_pend, m_ack;
  int         dur[6]    = '{AR, G, Y, AR, G, Y};
  logic [2:0] ns_tab[6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  int         exp_seq[16] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5, 0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit t, input bit e, input bit q);
    bit new_pend;
    if (r) begin
      m_ph = 0; m_left = AR; m_pend = 0; m_ack = 0;
    end else begin
      m_ack    = 0;
      new_pend = m_pend | q;
      if (e) begin
        if ((m_ph == 1 || m_ph == 4) && m_pend && m_left > CUT) begin
          m_left = CUT;
        end else if (t) begin
          if (m_left > 1) begin
            m_left--;
          end else begin
            if ((m_ph == 2 || m_ph == 5) && m_pend) begin
              m_ack    = 1;
              new_pend = q;
            end
            m_ph   = (m_ph + 1) % 6;
            m_left = dur[m_ph];
          end
        end
      end
      m_pend = new_pend;
    end
  endtask

  task automatic check_all();
    chk("state",    8'(state_dbg),      8'(m_ph));
    chk("remain",   8'(remain),         8'(m_left - 1));
    chk("ns_light", 8'(ns_light),       8'(ns_tab[m_ph]));
    chk("ew_light", 8'(ew_light),       8'(ew_tab[m_ph]));
    chk("last",     8'(phase_last),     8'(m_left == 1));
    chk("pre_last", 8'(phase_pre_last), 8'(m_left == 2));
    chk("ped_ack",  8'(ped_ack),        8'(m_ack));
  endtask

  task automatic step(input bit r, input bit t, input bit e, input bit q);
    rst = r; sec_tick = t; en = e; ped_req = q;
    @(posedge clk);
    model(r, t, e, q);
    #1;
    check_all();
  endtask

  // Tick every cycle until the model sits at the requested phase/seconds-left.
  task automatic run_to(input int ph, input int left);
    for (int i = 0; i < 100; i++) begin
      if (m_ph == ph && m_left == left) break;
      step(0, 1, 1, 0);
    end
    chk("reach_state",  8'(state_dbg), 8'(ph));
    chk("reach_remain", 8'(remain),    8'(left - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1; sec_tick = 0; en = 1; ped_req = 0;
    m_ph = 0; m_left = AR; m_pend = 0; m_ack = 0;

    // Reset state
    step(1, 0, 1, 0);
    step(1, 1, 1, 1);
    chk("rst_state",  8'(state_dbg), 8'd0);
    chk("rst_remain", 8'(remain),    8'd0);
    chk("rst_ns",     8'(ns_light),  8'b100);
    chk("rst_ew",     8'(ew_light),  8'b100);
    chk("rst_ack",    8'(ped_ack),   8'd0);

    // Tick every cycle: full light cycle
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0);
      chk("cycle_seq", 8'(state_dbg), 8'(exp_seq[i]));
      if (i < 5) chk("ns_g_remain", 8'(remain), 8'(4 - i));
    end

    // Ticks every 4 clocks: remain holds between ticks
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 0);
      repeat (3) step(0, 0, 1, 0);
    end

    // Pedestrian pulse in NS_G at remain=4
    run_to(1, 5);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("ped_clamp", 8'(remain), 8'd1);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("ped_to_yellow", 8'(state_dbg), 8'd2);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("ped_ack_pulse", 8'(ped_ack), 8'd1);
    step(0, 0, 1, 0);
    chk("ped_ack_once", 8'(ped_ack), 8'd0);
    step(0, 1, 1, 0);
    n = 0;
    while (state_dbg == 3'd4 && n < 20) begin
      step(0, 1, 1, 0);
      n++;
    end
    chk("full_green_ticks", 8'(n), 8'd5);

    // Request held across the yellow exit: acknowledged and re-latched
    run_to(2, 1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    chk("held_ack", 8'(ped_ack), 8'd1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    chk("held_clamp", 8'(remain), 8'd1);
    n = 0;
    while (state_dbg == 3'd4 && n < 20) begin
      step(0, 1, 1, 0);
      n++;
    end
    chk("clamped_green_ticks", 8'(n), 8'd2);

    // Enable low freezes state and count
    run_to(4, 4);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      chk("frozen_state",  8'(state_dbg), 8'd4);
      chk("frozen_remain", 8'(remain),    8'd3);
    end
    step(0, 1, 1, 0);
    chk("resume_remain", 8'(remain), 8'd2);

    // Reset mid-phase in EW_Y
    run_to(5, 2);
    step(1, 1, 1, 1);
    chk("midrst_state",  8'(state_dbg), 8'd0);
    chk("midrst_remain", 8'(remain),    8'd0);
    chk("midrst_ns",     8'(ns_light),  8'b100);
    chk("midrst_ew",     8'(ew_light),  8'b100);
    chk("midrst_ack",    8'(ped_ack),   8'd0);

    // Illegal encoding recovers to AR_NS
    run_to(4, 3);
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    m_ph = 0; m_left = AR;
    step(0, 0, 1, 0);
    chk("recover_state",  8'(state_dbg), 8'd0);
    chk("recover_remain", 8'(remain),    8'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
